// File: rtl/bk_subtractor_32bit_pipe.sv
// -----------------------------------------------------------------------------
// bk_subtractor_32bit_pipe
//
// Purpose:
//   Three-stage pipelined subtractor/comparator built on a Brent-Kung
//   parallel-prefix borrow network. It computes a - b - bin as
//   a + ~b + ~bin and accepts one operation per cycle.
//
//   R1: operands -> bitwise generate/propagate (g = a & ~b, p = a ^ ~b),
//       carry-in = ~bin, operand sign bits, tag.
//   R2: Brent-Kung upsweep group G/P at spans 1, 2, ... WIDTH/2.
//   R3: downsweep carries, difference and all flags (output registers).
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i / ready_o  request handshake (a_i, b_i, bin_i, tag_i)
//   valid_o / ready_i  result handshake (diff_o, flags, tag_o)
//   diff_o             a - b - bin modulo 2^WIDTH
//   borrow_o, lt_u_o   unsigned borrow-out (a < b + bin)
//   ovf_o              two's-complement overflow
//   zero_o             diff_o == 0
//   lt_s_o             signed less-than (diff MSB ^ ovf)
//   tag_o              tag returned with the result
// -----------------------------------------------------------------------------
module bk_subtractor_32bit_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             lt_u_o,
    output logic             lt_s_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int LOG   = $clog2(WIDTH);
    localparam int NODES = 2 * WIDTH - 2;   // all upsweep nodes, spans 1..WIDTH/2
    localparam int HALF  = WIDTH / 2;

    // Offset of level k in the full (uncompacted) upsweep node vector.
    function automatic int full_off(input int k);
        return 2 * WIDTH - 2 * (WIDTH >> k);
    endfunction

    // Index of node n of level k in the registered (compacted) vector.
    // Below the top level only even nodes are kept: an odd node at level k
    // is fully absorbed into its parent at level k+1 and is never needed by
    // the downsweep. The top level keeps both halves for the carry-out.
    function automatic int node_idx(input int k, input int n);
        if (k < LOG - 1) begin
            return (WIDTH - (WIDTH >> k)) + n / 2;
        end
        return (WIDTH - 2) + n;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake: one global enable advances every stage together.
    //   en = ~valid_o | ready_i ; ready_o = en.
    // A request transfers on a rising edge with valid_i && ready_o, a result
    // transfers with valid_o && ready_i. With en low every stage register
    // (data, tag, valid) holds, so outputs are stable while stalled. Bubbles
    // travel as valid=0 and are never collapsed. ready_o never depends on
    // valid_i.
    // -------------------------------------------------------------------------
    logic w_en;
    logic r1_valid;
    logic r2_valid;
    logic r3_valid;

    assign w_en    = ~r3_valid | ready_i;
    assign ready_o = w_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
        end else if (w_en) begin
            r1_valid <= valid_i;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
        end
    end

    // -------------------------------------------------------------------------
    // R1: bitwise generate/propagate of a + ~b. Data registers load only with a
    // real operation, so bubbles never push unknown input values downstream.
    // Only the operand sign bits are needed later (overflow).
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r1_g;
    logic [WIDTH-1:0] r1_p;
    logic             r1_cin;
    logic             r1_a_msb;
    logic             r1_b_msb;
    logic [TAG_W-1:0] r1_tag;

    always_ff @(posedge clk_i) begin
        if (w_en && valid_i) begin
            r1_g     <= a_i & ~b_i;
            r1_p     <= a_i ^ ~b_i;
            r1_cin   <= ~bin_i;
            r1_a_msb <= a_i[WIDTH-1];
            r1_b_msb <= b_i[WIDTH-1];
            r1_tag   <= tag_i;
        end
    end

    // -------------------------------------------------------------------------
    // Upsweep: level k node n covers bits [(n+1)*2^k-1 : n*2^k].
    // -------------------------------------------------------------------------
    logic [NODES-1:0] w_fg;
    logic [NODES-1:0] w_fp;
    logic [WIDTH-1:0] w_gc;
    logic [HALF-1:0]  w_pc;

    always_comb begin
        w_fg = '0;
        w_fp = '0;
        w_gc = '0;
        w_pc = '0;
        w_fg[WIDTH-1:0] = r1_g;
        w_fp[WIDTH-1:0] = r1_p;
        for (int k = 1; k < LOG; k++) begin
            for (int n = 0; n < (WIDTH >> k); n++) begin
                w_fg[full_off(k) + n] = w_fg[full_off(k-1) + 2*n + 1]
                                      | (w_fp[full_off(k-1) + 2*n + 1] & w_fg[full_off(k-1) + 2*n]);
                w_fp[full_off(k) + n] = w_fp[full_off(k-1) + 2*n + 1] & w_fp[full_off(k-1) + 2*n];
            end
        end
        for (int k = 0; k < LOG; k++) begin
            for (int n = 0; n < (WIDTH >> k); n++) begin
                if ((k == LOG - 1) || (n % 2 == 0)) begin
                    w_gc[node_idx(k, n)] = w_fg[full_off(k) + n];
                end
            end
        end
        // Level-0 propagates travel separately (they also form the sum bits).
        for (int k = 1; k < LOG; k++) begin
            for (int n = 0; n < (WIDTH >> k); n++) begin
                if ((k == LOG - 1) || (n % 2 == 0)) begin
                    w_pc[node_idx(k, n) - HALF] = w_fp[full_off(k) + n];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // R2: registered upsweep nodes.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r2_gc;
    logic [HALF-1:0]  r2_pc;
    logic [WIDTH-1:0] r2_p0;
    logic             r2_cin;
    logic             r2_a_msb;
    logic             r2_b_msb;
    logic [TAG_W-1:0] r2_tag;

    always_ff @(posedge clk_i) begin
        if (w_en && r1_valid) begin
            r2_gc    <= w_gc;
            r2_pc    <= w_pc;
            r2_p0    <= r1_p;
            r2_cin   <= r1_cin;
            r2_a_msb <= r1_a_msb;
            r2_b_msb <= r1_b_msb;
            r2_tag   <= r1_tag;
        end
    end

    // -------------------------------------------------------------------------
    // Downsweep: carry into bit j is the prefix over bits [j-1:0] combined with
    // cin. That range is tiled by the aligned upsweep nodes picked out by the
    // set bits of j (largest first, i.e. lowest bits first); folding them in
    // order gives the same terms the Brent-Kung distribution tree shares.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   w_c;
    logic             w_acc;
    logic             w_pk;
    int               w_lo;
    int               w_idx;

    always_comb begin
        w_c   = '0;
        w_acc = 1'b0;
        w_pk  = 1'b0;
        w_lo  = 0;
        w_idx = 0;
        w_c[0] = r2_cin;
        for (int j = 1; j <= WIDTH; j++) begin
            w_acc = r2_cin;
            w_lo  = 0;
            for (int k = LOG; k >= 0; k--) begin
                if (((j >> k) & 1) == 1) begin
                    if (k == LOG) begin
                        // Full-width span (carry-out only): both top-level halves.
                        w_idx = node_idx(LOG - 1, 0);
                        w_acc = r2_gc[w_idx] | (r2_pc[w_idx - HALF] & w_acc);
                        w_idx = node_idx(LOG - 1, 1);
                        w_acc = r2_gc[w_idx] | (r2_pc[w_idx - HALF] & w_acc);
                    end else begin
                        w_idx = node_idx(k, w_lo >> k);
                        if (k == 0) begin
                            w_pk = r2_p0[w_lo];
                        end else begin
                            w_pk = r2_pc[w_idx - HALF];
                        end
                        w_acc = r2_gc[w_idx] | (w_pk & w_acc);
                    end
                    w_lo = w_lo + (1 << k);
                end
            end
            w_c[j] = w_acc;
        end
    end

    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_ovf;

    assign w_diff   = r2_p0 ^ w_c[WIDTH-1:0];
    assign w_borrow = ~w_c[WIDTH];
    assign w_ovf    = (r2_a_msb != r2_b_msb) && (w_diff[WIDTH-1] != r2_a_msb);

    // -------------------------------------------------------------------------
    // R3: output registers.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r3_diff;
    logic             r3_borrow;
    logic             r3_ovf;
    logic             r3_zero;
    logic             r3_lt_u;
    logic             r3_lt_s;
    logic [TAG_W-1:0] r3_tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r3_diff   <= '0;
            r3_borrow <= 1'b0;
            r3_ovf    <= 1'b0;
            r3_zero   <= 1'b0;
            r3_lt_u   <= 1'b0;
            r3_lt_s   <= 1'b0;
            r3_tag    <= '0;
        end else if (w_en && r2_valid) begin
            r3_diff   <= w_diff;
            r3_borrow <= w_borrow;
            r3_ovf    <= w_ovf;
            r3_zero   <= ~|w_diff;
            r3_lt_u   <= w_borrow;
            r3_lt_s   <= w_diff[WIDTH-1] ^ w_ovf;
            r3_tag    <= r2_tag;
        end
    end

    assign valid_o  = r3_valid;
    assign diff_o   = r3_diff;
    assign borrow_o = r3_borrow;
    assign ovf_o    = r3_ovf;
    assign zero_o   = r3_zero;
    assign lt_u_o   = r3_lt_u;
    assign lt_s_o   = r3_lt_s;
    assign tag_o    = r3_tag;

endmodule

// File: doc/bk_subtractor_32bit_pipe.md
Name: bk_subtractor_32bit_pipe

Overview:
- Pipelined 32-bit subtractor/comparator built on a Brent-Kung parallel-prefix borrow network.
- Computes a_i - b_i - bin_i as a_i + ~b_i + ~bin_i, giving full throughput of one operation per cycle.
- Outputs difference, borrow, signed overflow and compare flags.
- Sits beside the combinational BK adder in the adder-architecture comparison set; it is the timing-closed, handshaked ALU datapath variant for the subtract/compare direction.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64; prefix tree depth is log2(WIDTH).
- TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request valid.
- ready_o  output  1  block can accept an operation this cycle.
- a_i  input  WIDTH  minuend.
- b_i  input  WIDTH  subtrahend.
- bin_i  input  1  borrow-in.
- tag_i  input  TAG_W  opaque tag, returned unchanged with the result.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- diff_o  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- borrow_o  output  1  unsigned borrow-out (inverse of adder carry-out).
- ovf_o  output  1  two's-complement overflow.
- zero_o  output  1  diff_o == 0.
- lt_u_o  output  1  unsigned a < b + bin; equals borrow_o.
- lt_s_o  output  1  signed less-than; diff_o[MSB] ^ ovf_o.
- tag_o  output  TAG_W  tag of the presented result.

Behaviour:
- Reset: on a clk_i edge with rst_i=1, all stage-valid bits clear. valid_o=0, diff_o=0, borrow_o=0, ovf_o=0, zero_o=0, lt_u_o=0, lt_s_o=0, tag_o=0. ready_o is 1 during the cycle after reset.
- Stage R1 (captures on accept): registers operands, tag, cin=~bin_i, and bitwise g=a&~b, p=a^~b.
- Stage R2: Brent-Kung upsweep. Registers group G/P at spans 1,2,4,...,WIDTH/2 nodes, plus registered p and cin.
- Stage R3 (output regs): downsweep distributes carries c[i]. diff = p ^ c[WIDTH-1:0]; cout = c[WIDTH]. All flags are computed and registered here.
- Flag rules:
  - borrow = ~cout.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - zero = ~|diff.
- Latency: an op accepted on edge N (valid_i && ready_o) appears with valid_o=1 after edge N+2, assuming no stall. Throughput is 1 op/cycle.
- Handshake:
  - Global enable: en = ~valid_o | ready_i.
  - ready_o = en. This is combinational from ready_i and valid_o; no path from valid_i.
  - When en=0, every stage register (data, tag, valid) holds. Outputs must stay bit-stable while valid_o=1 and ready_i=0.
  - When en=1, all stages shift by one. Bubbles propagate as valid=0 and are not collapsed.
  - valid_i=1 with ready_o=0: the request is not accepted. The source must hold it.
- Simultaneous accept and output pop in one cycle is legal; no dead cycle.
- Reset mid-operation: all in-flight ops are discarded and never emitted. Valid bits are 0 after the reset edge regardless of ready_i or valid_i.
- Data registers in R1/R2 need no reset. Output registers reset as listed above.
- No X on outputs after reset, even if inputs carry X while valid_i=0.

Test Plan:
- a=5, b=3, bin=0, tag=1 -> diff=2, borrow=0, ovf=0, zero=0, lt_u=0, lt_s=0, tag_o=1; valid_o high exactly 3 cycles after the accept cycle.
- a=0, b=1, bin=0 -> diff=0xFFFFFFFF, borrow=1, lt_u=1, lt_s=1, ovf=0.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, lt_s=1, borrow=0, lt_u=0.
- Borrow-in and zero flag:
  - a=7, b=7, bin=1 -> diff=0xFFFFFFFF, borrow=1.
  - Next op a=7, b=7, bin=0 -> diff=0, zero=1, borrow=0.
- Backpressure: 6 back-to-back ops (tags 0..5); hold ready_i=0 for 5 cycles once the first result is valid -> ready_o=0 throughout, outputs bit-stable; after release, tags 0..5 emerge in order with no loss or duplication; 10k random ops with random ready_i match a reference model of (a - b - bin) mod 2^32.
- Pipeline full, then rst_i=1 for one cycle -> valid_o=0 and all outputs 0 after that edge; no pre-reset tag is ever emitted; an op accepted on the first post-reset cycle appears 3 cycles later.
